inst_decode: RTL and testbench
==============================

INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The ports SHALL be as follows, one per line as name, direction, width, meaning:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instruction  in  32  fetched instruction, from the IF/ID register.
- pcIn  in  32  PC of that instruction, from the IF/ID register.
- freeze  in  1  hazard detected; the ID/EX register loads a bubble.
- flush  in  1  branch taken in EX; the ID/EX register loads a bubble.
- statusIn  in  4  NZCV flags, bit3 = N.
- wbEn  in  1  writeback enable.
- wbDest  in  4  writeback register index.
- wbValue  in  32  writeback data.
- src1  out  4  Rn, instruction[19:16], combinational, to the hazard unit.
- src2  out  4  Rd (instruction[15:12]) for STR, otherwise Rm (instruction[3:0]); combinational.
- twoSrc  out  1  high for STR, or for data-processing with I = 0; combinational.
- pcOut  out  32  registered PC.
- val1, val2  out  32 each  registered operand reads.
- destOut  out  4  registered Rd.
- imm  out  1  registered I bit.
- shiftOperand  out  12  registered instruction[11:0].
- signedImm24  out  24  registered instruction[23:0].
- exeCmd  out  4  registered ALU command.
- memRead, memWrite, wbEnOut, branch, sOut  out  1 each  registered control signals.

Function
REQ-003 Fields SHALL be decoded as: cond [31:28], mode [27:26], I [25], opcode [24:21], S [20].
REQ-004 For mode 00, opcode SHALL map to exeCmd as follows, with wbEnOut = 1 except CMP and TST:
- MOV 1101 -> 0001; MVN 1111 -> 1001.
- ADD 0100 -> 0010; ADC 0101 -> 0011.
- SUB 0010 -> 0100; SBC 0110 -> 0101.
- AND 0000 -> 0110; ORR 1100 -> 0111; EOR 0001 -> 1000.
- CMP 1010 -> 0100; TST 1000 -> 0110.
- Any other opcode -> all control signals 0.
REQ-005 sOut SHALL equal S for mode 00, and SHALL be 0 for modes 01 and 10.
REQ-006 Mode 01 SHALL set exeCmd = 0010; S = 1 gives LDR (memRead = 1, wbEnOut = 1); S = 0 gives STR (memWrite = 1).
REQ-007 Mode 10 SHALL set branch = 1 and all other control signals to 0.
REQ-008 Condition check SHALL be standard ARM semantics on statusIn:
- EQ / NE on Z; CS / CC on C; MI / PL on N; VS / VC on V.
- HI = C & ~Z; LS = ~C | Z.
- GE = (N == V); LT = (N != V); GT = ~Z & (N == V); LE = Z | (N != V).
- AL = 1; cond 1111 = 0.
REQ-009 A failed condition SHALL force exeCmd, memRead, memWrite, wbEnOut, branch and sOut to 0 (bubble); data fields SHALL still load.
REQ-010 The register file SHALL hold R0..R14, 32 bits each, written on the rising clk edge when wbEn = 1 and wbDest != 15.
REQ-011 A wbDest of 15 SHALL be ignored.
REQ-012 A read of index 15 SHALL return pcIn.
REQ-013 val1 SHALL be read at src1 and val2 at src2.
REQ-014 The ID/EX outputs SHALL update on every rising edge with one-cycle latency from instruction.
REQ-015 When freeze or flush is 1, the ID/EX register SHALL load all control signals 0; data fields load normally.
REQ-016 When freeze and flush are both 1, the result SHALL be identical to REQ-015.
REQ-017 src1, src2 and twoSrc SHALL be purely combinational and SHALL be unaffected by freeze and flush.

Reset
REQ-018 rst SHALL asynchronously clear R0..R14 and every registered output to 0.
REQ-019 An rst asserted mid-pipeline SHALL discard the in-flight instruction; the first edge after rst deasserts SHALL load the current inputs.

Configuration
REQ-020 With WB_BYPASS_EN defined, a same-cycle read of wbDest while wbEn = 1 SHALL return wbValue (write-through).
REQ-021 Without WB_BYPASS_EN, that read SHALL return the stored pre-write value.

Structure
REQ-022 A shared package SHALL hold:
- exeCmd encodings;
- opcode and mode constants;
- condition-code constants;
- the NZCV bit positions.
REQ-023 The register file SHALL be a separate sub-module named register_file, containing the bypass logic.
REQ-024 Decode, the condition check and the ID/EX register SHALL reside in inst_decode.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- MOV R1,#5: instruction 0xE3A01005, AL -> next cycle exeCmd = 0001, wbEnOut = 1, imm = 1, destOut = 1, shiftOperand = 0x005.
- Write back then ADD: wbEn = 1, wbDest = 1, wbValue = 7, then 0xE0812001 -> val1 = val2 = 7, exeCmd = 0010, twoSrc = 1; same-cycle variant returns 7 only with WB_BYPASS_EN.
- CMP then BEQ:
  - 0xE3510005 -> wbEnOut = 0, sOut = 1;
  - 0x0A000002 with statusIn = 0100 -> branch = 1, signedImm24 = 0x000002;
  - same BEQ with statusIn = 0000 -> branch = 0.
- STR: 0xE5801000 -> memWrite = 1, src2 = 1, twoSrc = 1; LDR 0xE5901000 -> memRead = 1, wbEnOut = 1.
- freeze = 1 with ADD -> all control signals 0, pcOut still updates; flush identical; both asserted identical.
- rst pulse asserted between edges -> outputs 0 immediately; a later read of R1 returns 0; wbDest = 15 write has no effect.

Source files
------------

// File: rtl/inst_decode_pkg.sv
// Shared definitions for the ID stage: ALU command encodings, instruction
// field constants, condition codes, NZCV bit positions and the ID/EX record.
package inst_decode_pkg;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [3:0] PC_INDEX = 4'hF;

  typedef struct packed {
    exe_cmd_e exe_cmd;
    logic     mem_read;
    logic     mem_write;
    logic     wb_en;
    logic     branch;
    logic     s;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{EXE_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [3:0]  dest;
    logic        imm;
    logic [11:0] shift_operand;
    logic [23:0] signed_imm24;
    ctrl_t       ctrl;
  } id_ex_t;

  // ARM condition evaluation against the NZCV flags; 1111 never executes.
  function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inst_decode_register_file.sv
// register_file: R0..R14, two combinational read ports, one write port.
// Index 15 reads as the PC of the instruction in decode; writes to 15 are
// dropped. Define WB_BYPASS_EN to make a same-cycle read of the register
// being written return the incoming writeback value.
module register_file
  import inst_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rd_addr1,
  input  logic [3:0]  rd_addr2,
  input  logic [31:0] pc_in,
  input  logic        wb_en,
  input  logic [3:0]  wb_dest,
  input  logic [31:0] wb_value,
  output logic [31:0] rd_data1,
  output logic [31:0] rd_data2
);

  logic [31:0] regs_q [15];
  logic [31:0] regs_d [15];
  logic        wr_hit;

  assign wr_hit = wb_en && (wb_dest != PC_INDEX);

  // Next register contents: hold, except the addressed entry on a write.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    regs_d = regs_q;
    if (wr_hit) regs_d[wb_dest] = wb_value;
  end

  // Register storage, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this array is architecturally visible after reset, so it is reset like any other state.
    if (rst) begin
      for (int i = 0; i < 15; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      regs_q <= regs_d;
    end
  end

  // Read ports, PC substitution for index 15, optional write-through.
  always_comb begin
    rd_data1 = (rd_addr1 == PC_INDEX) ? pc_in : regs_q[rd_addr1];
    rd_data2 = (rd_addr2 == PC_INDEX) ? pc_in : regs_q[rd_addr2];
`ifdef WB_BYPASS_EN
    if (wr_hit && (wb_dest == rd_addr1)) rd_data1 = wb_value;
    if (wr_hit && (wb_dest == rd_addr2)) rd_data2 = wb_value;
`endif
  end

endmodule

// File: rtl/inst_decode.sv
// inst_decode: ID stage. Decodes the instruction, evaluates its condition,
// reads operands from register_file and registers everything into ID/EX.
// Optional feature macro: WB_BYPASS_EN (register file write-through).
module inst_decode
  import inst_decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic [31:0] pcIn,
  input  logic        freeze,
  input  logic        flush,
  input  logic [3:0]  statusIn,
  input  logic        wbEn,
  input  logic [3:0]  wbDest,
  input  logic [31:0] wbValue,
  output logic [3:0]  src1,
  output logic [3:0]  src2,
  output logic        twoSrc,
  output logic [31:0] pcOut,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [3:0]  destOut,
  output logic        imm,
  output logic [11:0] shiftOperand,
  output logic [23:0] signedImm24,
  output logic [3:0]  exeCmd,
  output logic        memRead,
  output logic        memWrite,
  output logic        wbEnOut,
  output logic        branch,
  output logic        sOut
);

  logic [3:0]  cond;
  logic [1:0]  mode;
  logic        i_bit;
  logic [3:0]  opcode;
  logic        s_bit;
  logic        is_str;
  logic [31:0] rd_data1, rd_data2;
  ctrl_t       ctrl;
  id_ex_t      id_ex_d, id_ex_q;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign i_bit  = instruction[25];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];

  // Operand selection for the hazard unit; independent of freeze/flush.
  always_comb begin
    is_str = (mode == MODE_MEM) && !s_bit;
    src1   = instruction[19:16];
    src2   = is_str ? instruction[15:12] : instruction[3:0];
    twoSrc = is_str || ((mode == MODE_DP) && !i_bit);
  end

  register_file u_register_file (
    .clk      (clk),
    .rst      (rst),
    .rd_addr1 (src1),
    .rd_addr2 (src2),
    .pc_in    (pcIn),
    .wb_en    (wbEn),
    .wb_dest  (wbDest),
    .wb_value (wbValue),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  // Control decode from mode/opcode/S; unknown encodings yield a bubble.
  always_comb begin
    ctrl = CTRL_BUBBLE;
    case (mode)
      MODE_DP: begin
        ctrl.wb_en = 1'b1;
        ctrl.s     = s_bit;
        case (opcode)
          OP_MOV: ctrl.exe_cmd = EXE_MOV;
          OP_MVN: ctrl.exe_cmd = EXE_MVN;
          OP_ADD: ctrl.exe_cmd = EXE_ADD;
          OP_ADC: ctrl.exe_cmd = EXE_ADC;
          OP_SUB: ctrl.exe_cmd = EXE_SUB;
          OP_SBC: ctrl.exe_cmd = EXE_SBC;
          OP_AND: ctrl.exe_cmd = EXE_AND;
          OP_ORR: ctrl.exe_cmd = EXE_ORR;
          OP_EOR: ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin ctrl.exe_cmd = EXE_SUB; ctrl.wb_en = 1'b0; end
          OP_TST: begin ctrl.exe_cmd = EXE_AND; ctrl.wb_en = 1'b0; end
          default: ctrl = CTRL_BUBBLE;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd   = EXE_ADD;
        ctrl.mem_read  = s_bit;
        ctrl.wb_en     = s_bit;
        ctrl.mem_write = !s_bit;
      end
      MODE_BR: ctrl.branch = 1'b1;
      default: ctrl = CTRL_BUBBLE;
    endcase
  end

  // Next ID/EX contents: data always loads, control is squashed on bubble.
  always_comb begin
    id_ex_d.pc            = pcIn;
    id_ex_d.val1          = rd_data1;
    id_ex_d.val2          = rd_data2;
    id_ex_d.dest          = instruction[15:12];
    id_ex_d.imm           = i_bit;
    id_ex_d.shift_operand = instruction[11:0];
    id_ex_d.signed_imm24  = instruction[23:0];
    id_ex_d.ctrl          = ctrl;
    if (freeze || flush || !cond_passed(cond, statusIn)) id_ex_d.ctrl = CTRL_BUBBLE;
  end

  // ID/EX pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) id_ex_q <= '0;
    else     id_ex_q <= id_ex_d;
  end

  assign pcOut        = id_ex_q.pc;
  assign val1         = id_ex_q.val1;
  assign val2         = id_ex_q.val2;
  assign destOut      = id_ex_q.dest;
  assign imm          = id_ex_q.imm;
  assign shiftOperand = id_ex_q.shift_operand;
  assign signedImm24  = id_ex_q.signed_imm24;
  assign exeCmd       = id_ex_q.ctrl.exe_cmd;
  assign memRead      = id_ex_q.ctrl.mem_read;
  assign memWrite     = id_ex_q.ctrl.mem_write;
  assign wbEnOut      = id_ex_q.ctrl.wb_en;
  assign branch       = id_ex_q.ctrl.branch;
  assign sOut         = id_ex_q.ctrl.s;

endmodule

// File: tb/tb_inst_decode.sv
// Directed bench for inst_decode with hand-computed expected values.
module tb_inst_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, pcIn, wbValue;
  logic        freeze, flush, wbEn;
  logic [3:0]  statusIn, wbDest;
  logic [3:0]  src1, src2, destOut, exeCmd;
  logic        twoSrc, imm, memRead, memWrite, wbEnOut, branch, sOut;
  logic [31:0] pcOut, val1, val2;
  logic [11:0] shiftOperand;
  logic [23:0] signedImm24;

  int n_checks = 0;
  int n_pass   = 0;

  inst_decode dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pcIn(pcIn),
    .freeze(freeze), .flush(flush), .statusIn(statusIn),
    .wbEn(wbEn), .wbDest(wbDest), .wbValue(wbValue),
    .src1(src1), .src2(src2), .twoSrc(twoSrc), .pcOut(pcOut),
    .val1(val1), .val2(val2), .destOut(destOut), .imm(imm),
    .shiftOperand(shiftOperand), .signedImm24(signedImm24), .exeCmd(exeCmd),
    .memRead(memRead), .memWrite(memWrite), .wbEnOut(wbEnOut),
    .branch(branch), .sOut(sOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // All six control outputs packed as {exeCmd, memRead, memWrite, wbEnOut, branch, sOut}.
  function automatic logic [31:0] ctl();
    return {23'd0, exeCmd, memRead, memWrite, wbEnOut, branch, sOut};
  endfunction

  localparam logic [31:0] ADD_R2_R1_R1 = 32'hE0812001;

  initial begin
    rst = 1'b1; instruction = '0; pcIn = '0; freeze = 0; flush = 0;
    statusIn = '0; wbEn = 0; wbDest = '0; wbValue = '0;
    tick();
    check("reset_ctl", ctl(), 32'h0);
    check("reset_pc", pcOut, 32'h0);
    check("reset_val1", val1, 32'h0);
    rst = 1'b0;

    // MOV R1,#5
    instruction = 32'hE3A01005; pcIn = 32'h100; #1;
    check("mov_twosrc", twoSrc, 32'h0);
    tick();
    check("mov_ctl", ctl(), {23'd0, 4'b0001, 5'b00100});
    check("mov_imm", imm, 32'h1);
    check("mov_dest", destOut, 32'h1);
    check("mov_shift", shiftOperand, 32'h005);
    check("mov_pc", pcOut, 32'h100);

    // Write back R1 = 7 under a failing-condition filler instruction.
    instruction = 32'h0; wbEn = 1; wbDest = 4'd1; wbValue = 32'd7;
    tick();
    check("filler_bubble", ctl(), 32'h0);
    wbEn = 0;

    // ADD R2,R1,R1
    instruction = ADD_R2_R1_R1; pcIn = 32'h104; #1;
    check("add_src1", src1, 32'h1);
    check("add_src2", src2, 32'h1);
    check("add_twosrc", twoSrc, 32'h1);
    tick();
    check("add_val1", val1, 32'd7);
    check("add_val2", val2, 32'd7);
    check("add_ctl", ctl(), {23'd0, 4'b0010, 5'b00100});
    check("add_dest", destOut, 32'h2);

    // Same-cycle write and read of R3.
    instruction = 32'hE0832003; wbEn = 1; wbDest = 4'd3; wbValue = 32'd9;
    tick();
`ifdef WB_BYPASS_EN
    check("samecyc_val1", val1, 32'd9);
    check("samecyc_val2", val2, 32'd9);
`else
    check("samecyc_val1", val1, 32'd0);
    check("samecyc_val2", val2, 32'd0);
`endif
    wbEn = 0;
    tick();
    check("r3_stored", val1, 32'd9);

    // CMP R1,#5
    instruction = 32'hE3510005;
    tick();
    check("cmp_ctl", ctl(), {23'd0, 4'b0100, 5'b00001});

    // BEQ taken / not taken
    instruction = 32'h0A000002; statusIn = 4'b0100;
    tick();
    check("beq_taken_ctl", ctl(), {23'd0, 4'b0000, 5'b00010});
    check("beq_imm24", signedImm24, 32'h000002);
    statusIn = 4'b0000;
    tick();
    check("beq_not_taken_ctl", ctl(), 32'h0);
    check("beq_imm24_nt", signedImm24, 32'h000002);

    // STR R1,[R0]
    instruction = 32'hE5801000; #1;
    check("str_src1", src1, 32'h0);
    check("str_src2", src2, 32'h1);
    check("str_twosrc", twoSrc, 32'h1);
    tick();
    check("str_ctl", ctl(), {23'd0, 4'b0010, 5'b01000});
    check("str_val2", val2, 32'd7);

    // LDR R1,[R0]
    instruction = 32'hE5901000; #1;
    check("ldr_twosrc", twoSrc, 32'h0);
    tick();
    check("ldr_ctl", ctl(), {23'd0, 4'b0010, 5'b10100});

    // Unknown data-processing opcode (0011)
    instruction = 32'hE0612001;
    tick();
    check("unk_ctl", ctl(), 32'h0);
    check("unk_dest", destOut, 32'h2);

    // freeze, flush, both: control squashed, data still loads.
    instruction = ADD_R2_R1_R1;
    for (int k = 0; k < 3; k++) begin
      freeze = (k != 1); flush = (k != 0); pcIn = 32'h200 + 32'(4 * k); #1;
      check("stall_src1", src1, 32'h1);
      check("stall_twosrc", twoSrc, 32'h1);
      tick();
      check("stall_ctl", ctl(), 32'h0);
      check("stall_pc", pcOut, 32'h200 + 32'(4 * k));
      check("stall_val1", val1, 32'd7);
    end
    freeze = 0; flush = 0;

    // Asynchronous reset pulse between edges.
    instruction = 32'hE3A01005; pcIn = 32'h300;
    tick();
    check("pre_rst_ctl", ctl(), {23'd0, 4'b0001, 5'b00100});
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctl", ctl(), 32'h0);
    check("rst_async_pc", pcOut, 32'h0);
    check("rst_async_dest", destOut, 32'h0);
    #1 rst = 1'b0;
    instruction = ADD_R2_R1_R1; pcIn = 32'h304;
    tick();
    check("post_rst_r1", val1, 32'h0);
    check("post_rst_ctl", ctl(), {23'd0, 4'b0010, 5'b00100});
    check("post_rst_pc", pcOut, 32'h304);

    // Write to index 15 is dropped; index 15 reads as pcIn.
    instruction = 32'hE08F200F; pcIn = 32'h308;
    wbEn = 1; wbDest = 4'hF; wbValue = 32'hDEADBEEF;
    tick();
    check("r15_read", val1, 32'h308);
    wbEn = 0;
    instruction = 32'hE08E200E;
    tick();
    check("r14_untouched", val1, 32'h0);
    instruction = ADD_R2_R1_R1;
    tick();
    check("r1_untouched", val1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
